// File: rtl/board_vga_renderer.sv
// 640x480@60 VGA renderer for the chess board: timing counters, square/offset
// sub-counters, and a two-stage pixel pipeline producing RGB332 pixels.
module board_vga_renderer #(
  parameter int SQ_PX       = 60,
  parameter int BOARD_X0    = 80,
  parameter int GLYPH_OFS   = 10,
  parameter int GLYPH_SCALE = 5
) (
  input  logic       full_clock,
  input  logic       Reset,
  input  logic       pixel_ce,
  output logic [5:0] board_rd_addr,
  input  logic [3:0] board_rd_piece,
  input  logic [5:0] cursor_addr,
  input  logic [5:0] selected_piece_addr,
  input  logic       hilite_selected_square,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] rgb,
  output logic       frame_start
);

  localparam logic [9:0] H_LAST     = 10'd799;
  localparam logic [9:0] H_VIS      = 10'd640;
  localparam logic [9:0] H_SYNC_BEG = 10'd656;
  localparam logic [9:0] H_SYNC_END = 10'd752;
  localparam logic [9:0] V_LAST     = 10'd524;
  localparam logic [9:0] V_VIS      = 10'd480;
  localparam logic [9:0] V_SYNC_BEG = 10'd490;
  localparam logic [9:0] V_SYNC_END = 10'd492;

  localparam logic [9:0] BX_FIRST = 10'(BOARD_X0);
  localparam logic [9:0] BX_PRE   = 10'(BOARD_X0 - 1);
  localparam logic [9:0] BX_END   = 10'(BOARD_X0 + 8 * SQ_PX);
  localparam logic [5:0] SQ_LAST  = 6'(SQ_PX - 1);
  localparam logic [5:0] EDGE_LO  = 6'd3;
  localparam logic [5:0] EDGE_HI  = 6'(SQ_PX - 4);
  localparam logic [5:0] G_BEG    = 6'(GLYPH_OFS);
  localparam logic [5:0] G_END    = 6'(GLYPH_OFS + 8 * GLYPH_SCALE);

  localparam logic [7:0] COL_BLACK  = 8'h00;
  localparam logic [7:0] COL_WHITE  = 8'hFF;
  localparam logic [7:0] COL_CURSOR = 8'h1C;
  localparam logic [7:0] COL_SELECT = 8'hFC;
  localparam logic [7:0] COL_LIGHT  = 8'hD5;
  localparam logic [7:0] COL_DARK   = 8'h68;

  // Glyph bitmaps: row r lives in bits [r*8 +: 8], column c is bit c of that row.
  localparam logic [63:0] GLYPH_PAWN   = {8'h7E, 8'h3C, 8'h18, 8'h3C, 8'h3C, 8'h18, 8'h00, 8'h00};
  localparam logic [63:0] GLYPH_KNIGHT = {8'h7E, 8'h3C, 8'h1C, 8'h1E, 8'h7C, 8'h3C, 8'h18, 8'h00};
  localparam logic [63:0] GLYPH_BISHOP = {8'h7E, 8'h3C, 8'h18, 8'h18, 8'h3C, 8'h2C, 8'h3C, 8'h18};
  localparam logic [63:0] GLYPH_ROOK   = {8'hFF, 8'h7E, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h7E, 8'h5A};
  localparam logic [63:0] GLYPH_QUEEN  = {8'h7E, 8'h3C, 8'h18, 8'h3C, 8'h3C, 8'h7E, 8'h5A, 8'h5A};
  localparam logic [63:0] GLYPH_KING   = {8'h7E, 8'h3C, 8'h3C, 8'h7E, 8'h3C, 8'h18, 8'h7E, 8'h18};

  // Bitmap cell index from an in-square offset, by threshold compares rather than division.
  function automatic logic [2:0] glyph_index(input logic [5:0] ofs);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (ofs >= 6'(GLYPH_OFS + k * GLYPH_SCALE)) idx = idx + 3'd1;
    end
    return idx;
  endfunction

  function automatic logic glyph_pixel(input logic [2:0] kind, input logic [5:0] bit_idx);
    logic result;
    case (kind)
      3'd1:    result = GLYPH_PAWN[bit_idx];
      3'd2:    result = GLYPH_KNIGHT[bit_idx];
      3'd3:    result = GLYPH_BISHOP[bit_idx];
      3'd4:    result = GLYPH_ROOK[bit_idx];
      3'd5:    result = GLYPH_QUEEN[bit_idx];
      3'd6:    result = GLYPH_KING[bit_idx];
      default: result = 1'b0;
    endcase
    return result;
  endfunction

  logic [9:0] h_cnt, v_cnt;
  logic [2:0] col, row;
  logic [5:0] sx, sy;
  logic       h_last, v_last;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pixel_ce) begin
      h_cnt <= h_last ? 10'd0 : h_cnt + 10'd1;
      if (h_last) v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
    end
  end

  logic in_board_x, in_board;
  assign in_board_x = (h_cnt >= BX_FIRST) && (h_cnt < BX_END);
  assign in_board   = in_board_x && (v_cnt < V_VIS);

  // Column/offset track h_cnt; they restart just before the board's first column.
  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset) begin
      col <= '0;
      sx  <= '0;
    end else if (pixel_ce) begin
      if (h_cnt == BX_PRE) begin
        col <= '0;
        sx  <= '0;
      end else if (in_board_x) begin
        if (sx == SQ_LAST) begin
          sx  <= '0;
          col <= col + 3'd1;
        end else begin
          sx <= sx + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset) begin
      row <= '0;
      sy  <= '0;
    end else if (pixel_ce && h_last) begin
      if (v_last) begin
        row <= '0;
        sy  <= '0;
      end else if (v_cnt < V_VIS) begin
        if (sy == SQ_LAST) begin
          sy  <= '0;
          row <= row + 3'd1;
        end else begin
          sy <= sy + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset) frame_start <= 1'b0;
    else       frame_start <= pixel_ce && h_last && v_last;
  end

  logic [5:0] square;
  logic       on_edge, in_glyph_box;
  assign square       = {row, col};
  assign on_edge      = (sx < EDGE_LO) || (sx > EDGE_HI) || (sy < EDGE_LO) || (sy > EDGE_HI);
  assign in_glyph_box = (sx >= G_BEG) && (sx < G_END) && (sy >= G_BEG) && (sy < G_END);

  logic       s1_in_board, s1_glyph_box, s1_cursor_edge, s1_fill, s1_dark;
  logic       s1_hsync, s1_vsync;
  logic [2:0] s1_gx, s1_gy;

  // Stage 1: address the board and capture per-square decisions with the cursor inputs.
  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset) begin
      board_rd_addr  <= '0;
      s1_in_board    <= 1'b0;
      s1_glyph_box   <= 1'b0;
      s1_cursor_edge <= 1'b0;
      s1_fill        <= 1'b0;
      s1_dark        <= 1'b0;
      s1_gx          <= '0;
      s1_gy          <= '0;
      s1_hsync       <= 1'b1;
      s1_vsync       <= 1'b1;
    end else if (pixel_ce) begin
      if (in_board) board_rd_addr <= square;
      s1_in_board    <= in_board;
      s1_glyph_box   <= in_glyph_box;
      s1_cursor_edge <= (square == cursor_addr) && on_edge;
      s1_fill        <= hilite_selected_square && (square == selected_piece_addr);
      s1_dark        <= row[0] ^ col[0];
      s1_gx          <= glyph_index(sx);
      s1_gy          <= glyph_index(sy);
      s1_hsync       <= !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
      s1_vsync       <= !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
    end
  end

  logic       glyph_on;
  logic [7:0] pixel_rgb;

  always_comb begin
    glyph_on  = s1_glyph_box && glyph_pixel(board_rd_piece[2:0], {s1_gy, s1_gx});
    pixel_rgb = COL_BLACK;
    if (!s1_in_board)        pixel_rgb = COL_BLACK;
    else if (glyph_on)       pixel_rgb = board_rd_piece[3] ? COL_BLACK : COL_WHITE;
    else if (s1_cursor_edge) pixel_rgb = COL_CURSOR;
    else if (s1_fill)        pixel_rgb = COL_SELECT;
    else if (s1_dark)        pixel_rgb = COL_DARK;
    else                     pixel_rgb = COL_LIGHT;
  end

  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset) begin
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (pixel_ce) begin
      rgb   <= pixel_rgb;
      hsync <= s1_hsync;
      vsync <= s1_vsync;
    end
  end

endmodule
